// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcode and flag definitions shared by the pipelined ALU.
// Build option: ALU_FWD_EN selects operand forwarding instead of issue stalls.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        FN_ADD   = 4'd0,
        FN_SUB   = 4'd1,
        FN_MUL   = 4'd2,
        FN_PASSA = 4'd3,
        FN_PASSB = 4'd4,
        FN_AND   = 4'd5,
        FN_OR    = 4'd6,
        FN_XOR   = 4'd7,
        FN_NOTA  = 4'd8,
        FN_NOTB  = 4'd9,
        FN_SRL1  = 4'd10,
        FN_SLL1  = 4'd11,
        FN_SRA1  = 4'd12,
        FN_SLTU  = 4'd13,
        FN_LDI   = 4'd14,
        FN_CLR   = 4'd15
    } func_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int NUM_FLAGS  = 2;

    // LDI carries its immediate in the source-index fields, so it never
    // depends on register contents and can never be a hazard consumer.
    function automatic logic reads_sources(input func_e f);
        return f != FN_LDI;
    endfunction

endpackage

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: combinational function unit of the pipelined ALU.
// Produces the DW-bit result and the carry/borrow flag for one operation.
module alu_pipe_exec
    import alu_pipe_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  func_e         func,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] result,
    output logic          carry
);

    logic [2*DW-1:0] product;
    logic [DW:0]     sum;
    logic [DW:0]     diff;

    // Evaluate the selected operation; operations without a carry rule leave carry low.
    always_comb begin
        product = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        result  = '0;
        carry   = 1'b0;
        case (func)
            FN_ADD: begin
                result = sum[DW-1:0];
                carry  = sum[DW];
            end
            FN_SUB: begin
                result = diff[DW-1:0];
                carry  = diff[DW];
            end
            FN_MUL: begin
                result = product[DW-1:0];
                carry  = |product[2*DW-1:DW];
            end
            FN_PASSA: result = a;
            FN_PASSB: result = b;
            FN_AND:   result = a & b;
            FN_OR:    result = a | b;
            FN_XOR:   result = a ^ b;
            FN_NOTA:  result = ~a;
            FN_NOTB:  result = ~b;
            FN_SRL1: begin
                result = {1'b0, a[DW-1:1]};
                carry  = a[0];
            end
            FN_SLL1: begin
                result = {a[DW-2:0], 1'b0};
                carry  = a[DW-1];
            end
            FN_SRA1:  result = {a[DW-1], a[DW-1:1]};
            FN_SLTU:  result = {{(DW-1){1'b0}}, (a < b)};
            FN_LDI:   result = imm;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe_param.sv
// alu_pipe_param: three-stage (ID/EX/WB) pipelined ALU with register file and
// write-through data memory. Build option ALU_FWD_EN: when defined, dependent
// operands are bypassed from the ID-stage ALU output or the EX result register
// and the block never stalls; otherwise in_ready drops until the producer retires.
module alu_pipe_param
    import alu_pipe_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4,
    parameter int AW = 8
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] rs1,
    input  logic [RW-1:0] rs2,
    input  logic [RW-1:0] rd,
    input  logic [3:0]    func,
    input  logic [AW-1:0] addr,
    output logic          out_valid,
    output logic [DW-1:0] z,
    output logic [RW-1:0] z_rd,
    output logic [AW-1:0] z_addr,
    output logic          carry,
    output logic          zero,
    input  logic [RW-1:0] rf_raddr,
    output logic [DW-1:0] rf_rdata,
    input  logic [AW-1:0] mem_raddr,
    output logic [DW-1:0] mem_rdata
);

    localparam int NREG = 2 ** RW;
    localparam int NMEM = 2 ** AW;

    logic [DW-1:0] regbank [NREG];
    logic [DW-1:0] mem [NMEM];

    // ID stage
    logic          id_valid;
    logic [DW-1:0] id_a;
    logic [DW-1:0] id_b;
    logic [DW-1:0] id_imm;
    logic [RW-1:0] id_rd;
    logic [AW-1:0] id_addr;
    func_e         id_func;

    // EX stage
    logic          ex_valid;
    logic [DW-1:0] ex_result;
    logic          ex_carry;
    logic [RW-1:0] ex_rd;
    logic [AW-1:0] ex_addr;

    // WB stage flags
    logic [NUM_FLAGS-1:0] wb_flags;

    func_e         in_func;
    logic          uses_src;
    logic          accept;
    logic [DW-1:0] imm_in;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_result;
    logic          alu_carry;
    logic          a_hit_id;
    logic          a_hit_ex;
    logic          b_hit_id;
    logic          b_hit_ex;

    assign in_func  = func_e'(func);
    assign uses_src = reads_sources(in_func);
    assign imm_in   = DW'({rs1, rs2});

    // An older instruction in ID or EX that targets a source register is a
    // pending producer; rd == rs within the same instruction is not.
    assign a_hit_id = uses_src && id_valid && (rs1 == id_rd);
    assign a_hit_ex = uses_src && ex_valid && (rs1 == ex_rd);
    assign b_hit_id = uses_src && id_valid && (rs2 == id_rd);
    assign b_hit_ex = uses_src && ex_valid && (rs2 == ex_rd);

`ifdef ALU_FWD_EN
    assign in_ready = 1'b1;
`else
    logic hazard;
    assign hazard   = a_hit_id || a_hit_ex || b_hit_id || b_hit_ex;
    assign in_ready = !hazard;
`endif

    assign accept = in_valid && in_ready;

    // Operand selection: register file by default, youngest producer first when bypassing.
    always_comb begin
        op_a = regbank[rs1];
        op_b = regbank[rs2];
`ifdef ALU_FWD_EN
        if (a_hit_id) begin
            op_a = alu_result;
        end else if (a_hit_ex) begin
            op_a = ex_result;
        end
        if (b_hit_id) begin
            op_b = alu_result;
        end else if (b_hit_ex) begin
            op_b = ex_result;
        end
`endif
    end

    alu_pipe_exec #(.DW(DW)) u_exec (
        .a      (id_a),
        .b      (id_b),
        .func   (id_func),
        .imm    (id_imm),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // ID register: capture operands and control for an accepted instruction.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_a     <= '0;
            id_b     <= '0;
            id_imm   <= '0;
            id_rd    <= '0;
            id_addr  <= '0;
            id_func  <= FN_ADD;
        end else begin
            id_valid <= accept;
            if (accept) begin
                id_a    <= op_a;
                id_b    <= op_b;
                id_imm  <= imm_in;
                id_rd   <= rd;
                id_addr <= addr;
                id_func <= in_func;
            end
        end
    end

    // EX register: hold the function-unit result and carry for retirement.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_result <= '0;
            ex_carry  <= 1'b0;
            ex_rd     <= '0;
            ex_addr   <= '0;
        end else begin
            ex_valid <= id_valid;
            if (id_valid) begin
                ex_result <= alu_result;
                ex_carry  <= alu_carry;
                ex_rd     <= id_rd;
                ex_addr   <= id_addr;
            end
        end
    end

    // WB register: publish the retired result and its flags.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            z_rd      <= '0;
            z_addr    <= '0;
            wb_flags  <= '0;
        end else begin
            out_valid <= ex_valid;
            if (ex_valid) begin
                z                    <= ex_result;
                z_rd                 <= ex_rd;
                z_addr               <= ex_addr;
                wb_flags[FLAG_CARRY] <= ex_carry;
                wb_flags[FLAG_ZERO]  <= (ex_result == '0);
            end
        end
    end

    assign carry = wb_flags[FLAG_CARRY];
    assign zero  = wb_flags[FLAG_ZERO];

    // Register file: cleared by reset, written by each retiring instruction.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regbank[i] <= '0;
            end
        end else if (ex_valid) begin
            regbank[ex_rd] <= ex_result;
        end
    end

    // Data memory: write-through of every retiring result, contents survive reset.
    always_ff @(posedge clk1) begin
        if (ex_valid) begin
            mem[ex_addr] <= ex_result;
        end
    end

    assign rf_rdata  = regbank[rf_raddr];
    assign mem_rdata = mem[mem_raddr];

endmodule
